tinyalu_responder: RTL

Command-responder end of the TinyALU start/done operation protocol. The requester drives operands A/B, an opcode and `start`; this block computes the result and answers with a one-cycle `done` pulse. Add/and/xor complete in one cycle, and multiply runs through a three-stage pipeline. It sits behind the `tinyalu_bfm` interface as the DUT that the bench tester exercises.

---
 rtl/tinyalu_pkg.sv | 42 ++++
 rtl/tinyalu_mul_pipe.sv | 37 +++
 rtl/tinyalu_responder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/tinyalu_pkg.sv
// Shared types for the TinyALU responder: opcode and FSM state enums,
// the default multiply latency and the single-cycle ALU helpers.
package tinyalu_pkg;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    rst_op = 3'b111
  } operation_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SINGLE   = 2'd1,
    MUL      = 2'd2,
    WAIT_LOW = 2'd3
  } resp_state_t;

  localparam int TINYALU_MUL_LAT_DEFAULT = 3;

  function automatic logic [15:0] alu_single(input logic [2:0] o,
                                             input logic [7:0] a,
                                             input logic [7:0] b);
    logic [15:0] r;
    r = 16'h0000;
    case (o)
      add_op:  r = {7'b0000000, ({1'b0, a} + {1'b0, b})};
      and_op:  r = {8'h00, (a & b)};
      xor_op:  r = {8'h00, (a ^ b)};
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  // 101 and 110 are the only encodings outside operation_t
  function automatic logic op_is_illegal(input logic [2:0] o);
    return (o == 3'b101) || (o == 3'b110);
  endfunction

endpackage

// File: rtl/tinyalu_mul_pipe.sv
// MUL_LAT-deep 8x8 multiplier pipeline; the product is formed in the first
// stage and a valid bit travels alongside it to the last stage.
module tinyalu_mul_pipe #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        in_valid,
  output logic [15:0] prod,
  output logic        out_valid
);

  logic [15:0]        data_q [MUL_LAT];
  logic [MUL_LAT-1:0] vld_q;

  // Pipeline registers: multiply into stage 0, then shift data and valid
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        data_q[i] <= 16'h0000;
      end
    end else begin
      vld_q     <= {vld_q[MUL_LAT-2:0], in_valid};
      data_q[0] <= {8'h00, a} * {8'h00, b};
      for (int i = 1; i < MUL_LAT; i++) begin
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign prod      = data_q[MUL_LAT-1];
  assign out_valid = vld_q[MUL_LAT-1];

endmodule

// File: rtl/tinyalu_responder.sv
// TinyALU start/done responder. Optional illegal-opcode reporting (err port)
// is enabled by defining TINYALU_RESP_ERR_EN.
module tinyalu_responder
  import tinyalu_pkg::*;
#(
  parameter int MUL_LAT = TINYALU_MUL_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        done,
  output logic [15:0] result
`ifdef TINYALU_RESP_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int CNT_W = $clog2(MUL_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

  resp_state_t      state_q;
  logic             armed_q;
  logic             done_q;
  logic [15:0]      result_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       a_q;
  logic [7:0]       b_q;
  logic [2:0]       op_q;
  logic [15:0]      res_d;
  logic             capture_s;
  logic             mul_go_s;
  logic [15:0]      mul_prod_s;
  logic             mul_valid_s;
`ifdef TINYALU_RESP_ERR_EN
  logic             err_q;
`endif

  assign capture_s = (state_q == IDLE) && start && armed_q;
  assign mul_go_s  = capture_s && (op == mul_op);

  tinyalu_mul_pipe #(.MUL_LAT(MUL_LAT)) u_mul_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .a         (A),
    .b         (B),
    .in_valid  (mul_go_s),
    .prod      (mul_prod_s),
    .out_valid (mul_valid_s)
  );

  // Single-cycle ALU result from the operands latched at capture
  always_comb begin
    res_d = alu_single(op_q, a_q, b_q);
  end

  // Responder FSM with registered done/result/err
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      armed_q  <= 1'b1;
      done_q   <= 1'b0;
      result_q <= 16'h0000;
      cnt_q    <= '0;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      op_q     <= 3'b000;
`ifdef TINYALU_RESP_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef TINYALU_RESP_ERR_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (capture_s) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= op;
            armed_q <= 1'b0;
            cnt_q   <= CNT_LOAD;
            case (op)
              add_op, and_op, xor_op: state_q <= SINGLE;
              mul_op:                 state_q <= MUL;
`ifdef TINYALU_RESP_ERR_EN
              3'b101, 3'b110:         state_q <= SINGLE;
`endif
              default:                state_q <= WAIT_LOW;
            endcase
          end
        end
        SINGLE: begin
          done_q  <= 1'b1;
`ifdef TINYALU_RESP_ERR_EN
          if (op_is_illegal(op_q)) begin
            err_q <= 1'b1;
          end else begin
            result_q <= res_d;
          end
`else
          result_q <= res_d;
`endif
          state_q <= WAIT_LOW;
        end
        MUL: begin
          // A counter/pipeline disagreement suppresses done rather than
          // publishing a product that never reached the last stage
          if (cnt_q == '0) begin
            if (mul_valid_s) begin
              done_q   <= 1'b1;
              result_q <= mul_prod_s;
            end
            state_q <= WAIT_LOW;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        WAIT_LOW: begin
          if (!start) begin
            armed_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done   = done_q;
  assign result = result_q;
`ifdef TINYALU_RESP_ERR_EN
  assign err    = err_q;
`endif

endmodule
